fetch_unit: RTL

Instruction fetch stage feeding the single-cycle execute datapath. Holds the architectural PC, issues word fetches to the instruction-memory bus over a valid/ready request plus response-valid return, and presents `instruction`, `pc` and `pcNext` to execute under a valid/ready handshake. Accepts redirects from branch/jump resolution, including a redirect that arrives while a fetch is outstanding. Any response to a fetch that has been redirected is discarded.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word at a time
// over a valid/ready memory bus and presents it to execute under valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pcNext,
   output logic        fetch_fault
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN,
      FAULT
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] fetchPc_q, fetchPc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        redirPend_q, redirPend_d;
   logic [31:0] redirTgt_q, redirTgt_d;
   logic        fault_q, fault_d;
   logic        misaligned;

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fetchPc_q   <= RESET_PC;
         instr_q     <= NOP;
         pc_q        <= RESET_PC;
         redirPend_q <= 1'b0;
         redirTgt_q  <= RESET_PC;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetchPc_q   <= fetchPc_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         redirPend_q <= redirPend_d;
         redirTgt_q  <= redirTgt_d;
         fault_q     <= fault_d;
      end
   end

   assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

   // Next-state logic. A redirect never disturbs an issued request: it is latched
   // and the outstanding response is drained before fetching at the target.
   always_comb begin
      state_d     = state_q;
      fetchPc_d   = fetchPc_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      redirPend_d = redirPend_q;
      redirTgt_d  = redirTgt_q;
      fault_d     = fault_q;
      if (misaligned) begin
         state_d = FAULT;
         fault_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (redirect_valid) begin
                  redirPend_d = 1'b1;
                  redirTgt_d  = redirect_target;
               end
               if (imem_req_ready) begin
                  state_d = (redirPend_q || redirect_valid) ? DRAIN : WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  if (imem_resp_valid) begin
                     fetchPc_d = redirect_target;
                     state_d   = REQ;
                  end else begin
                     redirPend_d = 1'b1;
                     redirTgt_d  = redirect_target;
                     state_d     = DRAIN;
                  end
               end else if (imem_resp_valid) begin
                  instr_d = imem_resp_data;
                  pc_d    = fetchPc_q;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  fetchPc_d = redirect_target;
                  state_d   = REQ;
               end else if (instr_ready) begin
                  fetchPc_d = fetchPc_q + 32'd4;
                  state_d   = REQ;
               end
            end
            DRAIN: begin
               if (redirect_valid) begin
                  redirTgt_d = redirect_target;
               end
               if (imem_resp_valid) begin
                  fetchPc_d   = redirect_valid ? redirect_target : redirTgt_q;
                  redirPend_d = 1'b0;
                  state_d     = REQ;
               end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   assign imem_req_valid = (state_q == REQ);
   assign imem_addr      = fetchPc_q;
   assign instr_valid    = (state_q == HOLD);
   assign instruction    = instr_q;
   assign pc             = pc_q;
   assign pcNext         = pc_q + 32'd4;
   assign fetch_fault    = fault_q;

endmodule
